mult_booth: RTL

MULT_BOOTH -- requirements
Module: mult_booth

---
 rtl/mult_booth_if.sv | 15 +
 rtl/mult_booth.sv | 81 ++++++++
 2 files changed

// File: rtl/mult_booth_if.sv
// Request/result bundle for the radix-2 Booth multiplier.
interface mult_booth_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    modport master (output start, output a, output b,
                    input  hi, input lo, input busy, input done);
    modport slave  (input  start, input a, input b,
                    output hi, output lo, output busy, output done);
endinterface

// File: rtl/mult_booth.sv
// Sequential signed 32x32 multiplier, radix-2 Booth, one iteration per clock.
module mult_booth (
    input logic        clk,
    input logic        reset,
    mult_booth_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [32:0] acc;
    logic [32:0] m;
    logic [31:0] q;
    logic        q1;
    logic [5:0]  cnt;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    logic [32:0] sum;
    logic [32:0] acc_nx;
    logic [31:0] q_nx;
    logic        q1_nx;

    // 33-bit accumulator keeps M = -2^31 representable; shift replicates acc[32].
    always_comb begin
        sum = acc;
        case ({q[0], q1})
            2'b01:   sum = acc + m;
            2'b10:   sum = acc - m;
            default: sum = acc;
        endcase
        acc_nx = {sum[32], sum[32:1]};
        q_nx   = {sum[0], q[31:1]};
        q1_nx  = q[0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            m     <= '0;
            q     <= '0;
            q1    <= 1'b0;
            cnt   <= '0;
            hi_r  <= '0;
            lo_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        m     <= {bus.a[31], bus.a};
                        acc   <= '0;
                        q     <= bus.b;
                        q1    <= 1'b0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_nx;
                    q   <= q_nx;
                    q1  <= q1_nx;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        hi_r  <= acc_nx[31:0];
                        lo_r  <= q_nx;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
endmodule
